// File: rtl/dcache_line_adapter.sv
// Bridges the data cache's 256-bit line port to a 64-bit, 4-beat burst memory.
// One line read becomes a burst fill, and one writeback becomes a burst write.
module dcache_line_adapter #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * (2 ** s_offset),
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_address,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int s_burst = s_line / s_beat;
    localparam int cnt_w   = $clog2(s_burst);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             state, next_state;
    logic [cnt_w-1:0]   count;
    logic [s_line-1:0]  line_buf;
    logic [s_line-1:0]  fill_line;
    logic [s_line-1:0]  rdata_q;
    logic [31:0]        addr_q;
    logic [31:0]        aligned_addr;
    logic               last_beat;
    logic               unused_addr_bits;

    assign aligned_addr     = {pmem_address[31:s_offset], {s_offset{1'b0}}};
    assign unused_addr_bits = ^pmem_address[s_offset-1:0];
    assign last_beat        = (count == cnt_w'(s_burst - 1));

    // Line buffer with the current beat merged in, so the last beat can be
    // published to pmem_rdata on the same edge it is accepted.
    always_comb begin
        fill_line = line_buf;
        fill_line[int'(count) * s_beat +: s_beat] = burst_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pmem_write)     next_state = WR_BURST;
                else if (pmem_read) next_state = RD_BURST;
            end
            RD_BURST: if (burst_resp && last_beat) next_state = DONE;
            WR_BURST: if (burst_resp && last_beat) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // NOTE: the wide line buffer is reset too, so no stale writeback data
    // can ever appear on burst_wdata after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            line_buf <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (pmem_write) begin
                        line_buf <= pmem_wdata;
                        addr_q   <= aligned_addr;
                    end else if (pmem_read) begin
                        addr_q   <= aligned_addr;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        line_buf <= fill_line;
                        count    <= count + 1'b1;
                        if (last_beat) rdata_q <= fill_line;
                    end
                end
                WR_BURST: begin
                    if (burst_resp) count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign burst_read    = (state == RD_BURST);
    assign burst_write   = (state == WR_BURST);
    assign pmem_resp     = (state == DONE);
    assign burst_address = addr_q;
    assign pmem_rdata    = rdata_q;
    assign burst_wdata   = line_buf[int'(count) * s_beat +: s_beat];

endmodule

// File: tb/tb_dcache_line_adapter.sv
// Directed plus randomized bench for dcache_line_adapter; a transaction-level
// model tracks the last filled line and the expected beats of each burst.
module tb_dcache_line_adapter;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int           vectors;
    int           miscompares;
    logic [255:0] model_rdata;
    logic [31:0]  model_addr;
    int           gap_q[4];
    logic [63:0]  beat_q[4];

    dcache_line_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_gaps(input int g0, input int g1, input int g2, input int g3);
        gap_q[0] = g0; gap_q[1] = g1; gap_q[2] = g2; gap_q[3] = g3;
    endtask

    task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
        beat_q[0] = b0; beat_q[1] = b1; beat_q[2] = b2; beat_q[3] = b3;
    endtask

    task automatic random_beats_gaps(input int max_gap);
        for (int i = 0; i < 4; i++) begin
            beat_q[i] = {$urandom, $urandom};
            gap_q[i]  = $urandom_range(0, max_gap);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_rd"},    256'(burst_read),    256'(0));
        check({tag, "_wr"},    256'(burst_write),   256'(0));
        check({tag, "_resp"},  256'(pmem_resp),     256'(0));
        check({tag, "_rdata"}, pmem_rdata,          model_rdata);
        check({tag, "_addr"},  256'(burst_address), 256'(model_addr));
    endtask

    // Read burst: beat i arrives after gap_q[i] stall cycles. A nonnegative
    // abort_beats returns early, with the burst in flight after that many beats.
    task automatic do_read(input logic [31:0] addr, input int abort_beats);
        logic [255:0] exp_line;
        exp_line     = model_rdata;
        pmem_read    = 1'b1;
        pmem_address = addr;
        burst_resp   = 1'b0;
        model_addr   = {addr[31:5], 5'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == abort_beats) return;
            for (int g = 0; g <= gap_q[i]; g++) begin
                @(negedge clk);
                check("rd_busy",  256'(burst_read),    256'(1));
                check("rd_nowr",  256'(burst_write),   256'(0));
                check("rd_noresp",256'(pmem_resp),     256'(0));
                check("rd_addr",  256'(burst_address), 256'(model_addr));
                check("rd_hold",  pmem_rdata,          model_rdata);
                pmem_address = $urandom;
                burst_resp   = (g == gap_q[i]);
                burst_rdata  = burst_resp ? beat_q[i] : {$urandom, $urandom};
            end
            exp_line[i*64 +: 64] = beat_q[i];
        end
        @(negedge clk);
        model_rdata = exp_line;
        check("rd_done_resp",  256'(pmem_resp),     256'(1));
        check("rd_done_rd",    256'(burst_read),    256'(0));
        check("rd_done_wr",    256'(burst_write),   256'(0));
        check("rd_done_line",  pmem_rdata,          model_rdata);
        check("rd_done_addr",  256'(burst_address), 256'(model_addr));
        pmem_read  = 1'b0;
        burst_resp = 1'($urandom_range(0, 1));
        @(negedge clk);
        burst_resp = 1'b0;
        idle_check("rd_after");
    endtask

    // Write burst; with also_read the read request stays high throughout and
    // the task returns in IDLE with pmem_read still asserted.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata, input logic also_read);
        pmem_write   = 1'b1;
        pmem_read    = also_read;
        pmem_wdata   = wdata;
        pmem_address = addr;
        burst_resp   = 1'b0;
        model_addr   = {addr[31:5], 5'b0};
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g <= gap_q[i]; g++) begin
                @(negedge clk);
                check("wr_busy",   256'(burst_write),   256'(1));
                check("wr_nord",   256'(burst_read),    256'(0));
                check("wr_noresp", 256'(pmem_resp),     256'(0));
                check("wr_addr",   256'(burst_address), 256'(model_addr));
                check("wr_beat",   256'(burst_wdata),   256'(wdata[i*64 +: 64]));
                check("wr_rdata",  pmem_rdata,          model_rdata);
                pmem_wdata   = {8{$urandom}};
                pmem_address = $urandom;
                burst_resp   = (g == gap_q[i]);
                burst_rdata  = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        check("wr_done_resp",  256'(pmem_resp),     256'(1));
        check("wr_done_wr",    256'(burst_write),   256'(0));
        check("wr_done_rd",    256'(burst_read),    256'(0));
        check("wr_done_rdata", pmem_rdata,          model_rdata);
        check("wr_done_addr",  256'(burst_address), 256'(model_addr));
        pmem_write = 1'b0;
        burst_resp = 1'($urandom_range(0, 1));
        @(negedge clk);
        burst_resp = 1'b0;
        idle_check("wr_after");
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        model_rdata  = '0;
        model_addr   = '0;
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        #1;
        idle_check("reset");
        check("reset_wdata", 256'(burst_wdata), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_check("post_reset");

        // Zero-wait read
        set_gaps(0, 0, 0, 0);
        set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        do_read(32'h0000_1234, -1);
        check("read_line", pmem_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        check("read_addr", 256'(burst_address), 256'(32'h0000_1220));

        // Zero-wait write
        do_write(32'h8000_00FF, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0);
        check("write_addr", 256'(burst_address), 256'(32'h8000_00E0));

        // Stalled read: responses on cycles 2, 5, 6, 10 after the request edge
        set_gaps(1, 2, 0, 3);
        set_beats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
        do_read(32'h0000_4040, -1);

        // Simultaneous read and write: write first, then the held read
        set_gaps(0, 1, 0, 0);
        do_write(32'h0000_7700, {8{32'h5A5A_A5A5}}, 1'b1);
        random_beats_gaps(2);
        do_read(32'h0000_7700, -1);

        // Spurious burst_resp in IDLE
        burst_resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_check("spurious");
        end
        burst_resp = 1'b0;

        // Reset in the middle of a read after two beats
        random_beats_gaps(1);
        do_read(32'h0000_9980, 2);
        @(posedge clk);
        #2;
        rst         = 1'b1;
        pmem_read   = 1'b0;
        burst_resp  = 1'b0;
        model_rdata = '0;
        model_addr  = '0;
        #1;
        idle_check("mid_reset");
        check("mid_reset_wdata", 256'(burst_wdata), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_check("after_abort");
        end
        set_gaps(0, 0, 0, 0);
        set_beats(64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
                  64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004);
        do_read(32'h0000_9980, -1);

        // Randomized mix of reads, writes and collisions
        for (int t = 0; t < 24; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                random_beats_gaps(3);
                do_read($urandom, -1);
            end else if (kind == 1) begin
                random_beats_gaps(3);
                do_write($urandom, {8{$urandom}}, 1'b0);
            end else begin
                random_beats_gaps(2);
                do_write($urandom, {8{$urandom}}, 1'b1);
                random_beats_gaps(2);
                do_read($urandom, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
